// File: rtl/enc_bin2onehot_stream_if.sv
// rtl/enc_bin2onehot_stream_if.sv - index-in / one-hot-out handshake bundle for enc_bin2onehot_stream
interface enc_bin2onehot_stream_if #(
   parameter int BIN_W = 4,
   parameter int OH_W  = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [BIN_W-1:0] in;
   logic             out_valid;
   logic             out_ready;
   logic [OH_W-1:0]  out;
   logic             out_err;

   modport master (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out, out_err
   );

   modport slave (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out, out_err
   );
endinterface

// File: rtl/enc_bin2onehot_stream.sv
// rtl/enc_bin2onehot_stream.sv - buffered binary-to-one-hot encoder with out-of-range flagging
// Optional saturating error counter port err_cnt is built only when ENC_ERR_CNT_EN is defined.
module enc_bin2onehot_stream #(
   parameter int BIN_W      = 4,
   parameter int OH_W       = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
`ifdef ENC_ERR_CNT_EN
   output logic [7:0] err_cnt,
`endif
   enc_bin2onehot_stream_if.slave s
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_kept;
   logic [CNT_W-1:0] count_next;
   logic             rst_done;
   logic             in_rdy;
   logic             out_vld;
   logic             push;
   logic             pop;
   logic [BIN_W-1:0] idx;
   logic             in_err;
   logic [OH_W-1:0]  in_oh;
   logic [OH_W-1:0]  out_q;
   logic             err_q;
   logic [OH_W-1:0]  oh_mem  [FIFO_DEPTH];
   logic             err_mem [FIFO_DEPTH];

   // rst_done delays in_ready until the first edge after reset release
   assign in_rdy      = rst_done && (count < CNT_W'(FIFO_DEPTH));
   assign out_vld     = (count != '0);
   assign s.in_ready  = in_rdy;
   assign s.out_valid = out_vld;
   assign s.out       = out_q;
   assign s.out_err   = err_q;
   assign idx         = s.in;

   always_comb begin
      in_err     = (32'(idx) >= 32'(OH_W));
      in_oh      = in_err ? '0 : (OH_W'(1) << idx);
      push       = s.in_valid && in_rdy;
      pop        = out_vld && s.out_ready;
      count_kept = count - CNT_W'(pop);
      count_next = count_kept + CNT_W'(push);
      rd_next    = rd_ptr + PTR_W'(pop);
   end

   // out_q/err_q always mirror the head entry; when no older entry survives, the head is the one being pushed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_done <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         count    <= count_next;
         rd_ptr   <= rd_next;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (count_next != '0) begin
            if (count_kept == '0) begin
               out_q <= in_oh;
               err_q <= in_err;
            end else begin
               out_q <= oh_mem[rd_next];
               err_q <= err_mem[rd_next];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         oh_mem[wr_ptr]  <= in_oh;
         err_mem[wr_ptr] <= in_err;
      end
   end

`ifdef ENC_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (push && in_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule
